// File: rtl/vx_scoreboard_ctrl_if.sv
// Handshake bundle between decode, the scoreboard controller, dispatch and writeback.
// Every valid/ready pair transfers on a rising edge where both are high; valid never depends on ready.
interface vx_scoreboard_ctrl_if #(
  parameter int NUM_WARPS = 4,
  parameter int NUM_REGS  = 64
);
  localparam int NW_BITS = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int NR_BITS = $clog2(NUM_REGS);

  logic               in_valid;
  logic [NW_BITS-1:0] in_wid;
  logic               in_wb;
  logic [NR_BITS-1:0] in_rd;
  logic [NR_BITS-1:0] in_rs1;
  logic [NR_BITS-1:0] in_rs2;
  logic [NR_BITS-1:0] in_rs3;
  logic               in_ready;

  logic               out_valid;
  logic [NW_BITS-1:0] out_wid;
  logic               out_wb;
  logic [NR_BITS-1:0] out_rd;
  logic               out_ready;

  logic               wb_valid;
  logic [NW_BITS-1:0] wb_wid;
  logic [NR_BITS-1:0] wb_rd;
  logic               wb_eop;

  modport slave (
    input  in_valid, in_wid, in_wb, in_rd, in_rs1, in_rs2, in_rs3,
    output in_ready,
    output out_valid, out_wid, out_wb, out_rd,
    input  out_ready,
    input  wb_valid, wb_wid, wb_rd, wb_eop
  );

  modport master (
    output in_valid, in_wid, in_wb, in_rd, in_rs1, in_rs2, in_rs3,
    input  in_ready,
    input  out_valid, out_wid, out_wb, out_rd,
    output out_ready,
    output wb_valid, wb_wid, wb_rd, wb_eop
  );
endinterface

// File: rtl/vx_scoreboard_ctrl.sv
// Register scoreboard: holds one decoded instruction until its sources/destination are not
// pending, marks rd busy on dispatch, clears it on end-of-packet writeback, flags stuck stalls.
module vx_scoreboard_ctrl #(
  parameter int NUM_WARPS   = 4,
  parameter int NUM_REGS    = 64,
  parameter int STALL_LIMIT = 1000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  vx_scoreboard_ctrl_if.slave  bus,
  output logic                 deadlock,
  output logic                 release_err
);
  localparam int NW_BITS = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int NR_BITS = $clog2(NUM_REGS);
  localparam int SC_BITS = $clog2(STALL_LIMIT + 1);
  localparam logic [SC_BITS-1:0] SC_MAX = SC_BITS'(STALL_LIMIT);

  typedef logic [NUM_WARPS-1:0][NUM_REGS-1:0] busy_t;

  busy_t              busy_q, busy_d;
  logic               stage_valid_q;
  logic [NW_BITS-1:0] stage_wid_q;
  logic               stage_wb_q;
  logic [NR_BITS-1:0] stage_rd_q;
  logic [NR_BITS-1:0] stage_rs1_q;
  logic [NR_BITS-1:0] stage_rs2_q;
  logic [NR_BITS-1:0] stage_rs3_q;
  logic [SC_BITS-1:0] stall_cnt_q, stall_cnt_d;
  logic               deadlock_q, deadlock_d;
  logic               release_err_q, release_err_d;

  logic hazard, stall, fire, accept, wb_release;

  // Ids outside the table (non power-of-two sizes) read as not busy.
  function automatic logic bit_busy(input busy_t tbl, input logic [NW_BITS-1:0] w,
                                    input logic [NR_BITS-1:0] r);
    if (int'(w) >= NUM_WARPS || int'(r) >= NUM_REGS) return 1'b0;
    return tbl[w][r];
  endfunction

  // Hazard uses the registered table only: a release becomes visible the cycle after.
  assign hazard = bit_busy(busy_q, stage_wid_q, stage_rs1_q)
                | bit_busy(busy_q, stage_wid_q, stage_rs2_q)
                | bit_busy(busy_q, stage_wid_q, stage_rs3_q)
                | (stage_wb_q & bit_busy(busy_q, stage_wid_q, stage_rd_q));

  assign stall         = stage_valid_q & hazard;
  assign bus.out_valid = stage_valid_q & ~hazard;
  assign fire          = bus.out_valid & bus.out_ready;
  assign bus.in_ready  = ~stage_valid_q | fire;
  assign accept        = bus.in_valid & bus.in_ready;
  assign wb_release    = bus.wb_valid & bus.wb_eop;

  assign bus.out_wid = stage_wid_q;
  assign bus.out_wb  = stage_wb_q;
  assign bus.out_rd  = stage_rd_q;
  assign deadlock    = deadlock_q;
  assign release_err = release_err_q;

  // Release first, then set, so a same-bit set in the same cycle wins.
  always_comb begin
    busy_d        = busy_q;
    release_err_d = release_err_q;
    if (wb_release && int'(bus.wb_wid) < NUM_WARPS && int'(bus.wb_rd) < NUM_REGS) begin
      if (!busy_q[bus.wb_wid][bus.wb_rd] && bus.wb_rd != '0) release_err_d = 1'b1;
      busy_d[bus.wb_wid][bus.wb_rd] = 1'b0;
    end
    if (fire && stage_wb_q && stage_rd_q != '0 &&
        int'(stage_wid_q) < NUM_WARPS && int'(stage_rd_q) < NUM_REGS) begin
      busy_d[stage_wid_q][stage_rd_q] = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = '0;
    if (stall) stall_cnt_d = (stall_cnt_q == SC_MAX) ? stall_cnt_q : stall_cnt_q + 1'b1;
    deadlock_d = deadlock_q | (stall_cnt_d == SC_MAX);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q        <= '0;
      stage_valid_q <= 1'b0;
      stage_wid_q   <= '0;
      stage_wb_q    <= 1'b0;
      stage_rd_q    <= '0;
      stage_rs1_q   <= '0;
      stage_rs2_q   <= '0;
      stage_rs3_q   <= '0;
      stall_cnt_q   <= '0;
      deadlock_q    <= 1'b0;
      release_err_q <= 1'b0;
    end else begin
      busy_q        <= busy_d;
      stall_cnt_q   <= stall_cnt_d;
      deadlock_q    <= deadlock_d;
      release_err_q <= release_err_d;
      if (accept) begin
        stage_valid_q <= 1'b1;
        stage_wid_q   <= bus.in_wid;
        stage_wb_q    <= bus.in_wb;
        stage_rd_q    <= bus.in_rd;
        stage_rs1_q   <= bus.in_rs1;
        stage_rs2_q   <= bus.in_rs2;
        stage_rs3_q   <= bus.in_rs3;
      end else if (fire) begin
        stage_valid_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_vx_scoreboard_ctrl.sv
// Directed bench for vx_scoreboard_ctrl: per-cycle vector table plus hand-written
// deadlock and reset-mid-stall sequences.
module tb_vx_scoreboard_ctrl;
  localparam int NW_BITS = 2;
  localparam int NR_BITS = 6;

  logic clk;
  logic reset_n;
  logic deadlock;
  logic release_err;

  vx_scoreboard_ctrl_if #(.NUM_WARPS(4), .NUM_REGS(64)) bus ();

  vx_scoreboard_ctrl #(.NUM_WARPS(4), .NUM_REGS(64), .STALL_LIMIT(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .deadlock    (deadlock),
    .release_err (release_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic iv; int iw; logic iwb; int ird; int rs1; int rs2; int rs3;
    logic ordy;
    logic wv; int ww; int wr; logic we;
    logic e_ir; logic e_ov; int e_ow; int e_ord; logic e_rerr;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

  task automatic add(input logic iv, input int iw, input logic iwb, input int ird,
                     input int rs1, input int rs2, input int rs3, input logic ordy,
                     input logic wv, input int ww, input int wr, input logic we,
                     input logic e_ir, input logic e_ov, input int e_ow, input int e_ord,
                     input logic e_rerr);
    vec_t v;
    v.iv = iv; v.iw = iw; v.iwb = iwb; v.ird = ird; v.rs1 = rs1; v.rs2 = rs2; v.rs3 = rs3;
    v.ordy = ordy; v.wv = wv; v.ww = ww; v.wr = wr; v.we = we;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_ow = e_ow; v.e_ord = e_ord; v.e_rerr = e_rerr;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic iv, input int iw, input logic iwb, input int ird,
                       input int rs1, input int rs2, input int rs3, input logic ordy,
                       input logic wv, input int ww, input int wr, input logic we);
    bus.in_valid  = iv;
    bus.in_wid    = NW_BITS'(iw);
    bus.in_wb     = iwb;
    bus.in_rd     = NR_BITS'(ird);
    bus.in_rs1    = NR_BITS'(rs1);
    bus.in_rs2    = NR_BITS'(rs2);
    bus.in_rs3    = NR_BITS'(rs3);
    bus.out_ready = ordy;
    bus.wb_valid  = wv;
    bus.wb_wid    = NW_BITS'(ww);
    bus.wb_rd     = NR_BITS'(wr);
    bus.wb_eop    = we;
  endtask

  task automatic idle(input logic ordy);
    drive(0, 0, 0, 0, 0, 0, 0, ordy, 0, 0, 0, 0);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Each row is one cycle: inputs, then expected in_ready, out_valid, out_wid, out_rd, release_err.
    // Back-to-back issue across warps.
    add(1,0,1,5, 1,2,0, 1, 0,0,0,0, 1,0,0,0, 0);
    add(1,1,1,6, 5,0,0, 1, 0,0,0,0, 1,1,0,5, 0);
    add(0,0,0,0, 0,0,0, 1, 0,0,0,0, 1,1,1,6, 0);
    add(0,0,0,0, 0,0,0, 1, 0,0,0,0, 1,0,1,6, 0);
    // RAW stall on w0 r5; non-eop writeback ignored; eop release opens next cycle.
    add(1,0,1,7, 5,0,0, 1, 0,0,0,0, 1,0,1,6, 0);
    add(1,0,1,8, 0,0,0, 1, 0,0,0,0, 0,0,0,7, 0);
    add(1,0,1,8, 0,0,0, 1, 0,0,0,0, 0,0,0,7, 0);
    add(1,0,1,8, 0,0,0, 1, 1,0,5,0, 0,0,0,7, 0);
    add(1,0,1,8, 0,0,0, 1, 1,0,5,1, 0,0,0,7, 0);
    add(1,0,1,8, 0,0,0, 1, 0,0,0,0, 1,1,0,7, 0);
    add(0,0,0,0, 0,0,0, 1, 0,0,0,0, 1,1,0,8, 0);
    // WAW on w2 r9, then rd=0 writers never block each other.
    add(1,2,1,9, 1,2,3, 1, 0,0,0,0, 1,0,0,8, 0);
    add(1,2,1,9, 4,0,0, 1, 0,0,0,0, 1,1,2,9, 0);
    add(0,0,0,0, 0,0,0, 1, 0,0,0,0, 0,0,2,9, 0);
    add(0,0,0,0, 0,0,0, 1, 1,2,9,1, 0,0,2,9, 0);
    add(1,2,1,0, 0,0,0, 1, 0,0,0,0, 1,1,2,9, 0);
    add(1,2,1,0, 0,0,0, 1, 0,0,0,0, 1,1,2,0, 0);
    add(0,0,0,0, 0,0,0, 1, 0,0,0,0, 1,1,2,0, 0);
    add(0,0,0,0, 0,0,0, 1, 0,0,0,0, 1,0,2,0, 0);
    // Backpressure: five held cycles with a competing offer; no self-hazard may appear.
    add(1,3,1,10, 1,0,0, 0, 0,0,0,0, 1,0,2,0, 0);
    for (int i = 0; i < 5; i++) add(1,3,1,11, 0,0,0, 0, 0,0,0,0, 0,1,3,10, 0);
    add(0,0,0,0, 0,0,0, 1, 0,0,0,0, 1,1,3,10, 0);
    add(0,0,0,0, 0,0,0, 1, 0,0,0,0, 1,0,3,10, 0);
    // Release of a never-issued register.
    add(0,0,0,0, 0,0,0, 1, 1,3,12,1, 1,0,3,10, 0);
    add(0,0,0,0, 0,0,0, 1, 0,0,0,0, 1,0,3,10, 1);
    // Same-cycle set and release: different bits both apply, same bit keeps set.
    add(1,1,1,12, 0,0,0, 1, 0,0,0,0, 1,0,3,10, 1);
    add(0,0,0,0, 0,0,0, 1, 1,1,6,1, 1,1,1,12, 1);
    add(1,1,1,13, 6,0,0, 1, 0,0,0,0, 1,0,1,12, 1);
    add(0,0,0,0, 0,0,0, 1, 1,1,13,1, 1,1,1,13, 1);
    add(1,1,1,14, 13,0,0, 1, 0,0,0,0, 1,0,1,13, 1);
    add(0,0,0,0, 0,0,0, 1, 0,0,0,0, 0,0,1,14, 1);
    add(0,0,0,0, 0,0,0, 1, 1,1,13,1, 0,0,1,14, 1);
    add(0,0,0,0, 0,0,0, 1, 0,0,0,0, 1,1,1,14, 1);
    add(0,0,0,0, 0,0,0, 1, 0,0,0,0, 1,0,1,14, 1);
    // rs2 and rs3 hazards; a non-writing instruction ignores a busy rd.
    add(1,0,0,0, 0,7,0, 1, 0,0,0,0, 1,0,1,14, 1);
    add(0,0,0,0, 0,0,0, 1, 1,0,7,1, 0,0,0,0, 1);
    add(1,0,0,0, 0,0,8, 1, 0,0,0,0, 1,1,0,0, 1);
    add(0,0,0,0, 0,0,0, 1, 1,0,8,1, 0,0,0,0, 1);
    add(0,0,0,0, 0,0,0, 1, 0,0,0,0, 1,1,0,0, 1);
    add(1,1,0,14, 0,0,0, 1, 0,0,0,0, 1,0,0,0, 1);
    add(0,0,0,0, 0,0,0, 1, 0,0,0,0, 1,1,1,14, 1);
    add(0,0,0,0, 0,0,0, 1, 0,0,0,0, 1,0,1,14, 1);

    // Reset state
    reset_n = 1'b0;
    idle(1);
    #2;
    chk("reset in_ready", int'(bus.in_ready), 1);
    chk("reset out_valid", int'(bus.out_valid), 0);
    chk("reset deadlock", int'(deadlock), 0);
    chk("reset release_err", int'(release_err), 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      step();
      drive(tbl[i].iv, tbl[i].iw, tbl[i].iwb, tbl[i].ird, tbl[i].rs1, tbl[i].rs2, tbl[i].rs3,
            tbl[i].ordy, tbl[i].wv, tbl[i].ww, tbl[i].wr, tbl[i].we);
      @(negedge clk);
      chk($sformatf("v%0d in_ready", i), int'(bus.in_ready), int'(tbl[i].e_ir));
      chk($sformatf("v%0d out_valid", i), int'(bus.out_valid), int'(tbl[i].e_ov));
      chk($sformatf("v%0d out_wid", i), int'(bus.out_wid), tbl[i].e_ow);
      chk($sformatf("v%0d out_rd", i), int'(bus.out_rd), tbl[i].e_ord);
      chk($sformatf("v%0d release_err", i), int'(release_err), int'(tbl[i].e_rerr));
      chk($sformatf("v%0d deadlock", i), int'(deadlock), 0);
    end

    // Deadlock: w2 r9 is still busy; a reader of it stalls for the full limit of 8.
    step();
    drive(1, 2, 1, 1, 9, 0, 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    chk("dl load in_ready", int'(bus.in_ready), 1);
    for (int k = 0; k <= 8; k++) begin
      step();
      idle(1);
      @(negedge clk);
      chk($sformatf("dl stall%0d out_valid", k), int'(bus.out_valid), 0);
      chk($sformatf("dl stall%0d deadlock", k), int'(deadlock), (k == 8) ? 1 : 0);
    end
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 9, 1);
    @(negedge clk);
    chk("dl release out_valid", int'(bus.out_valid), 0);
    step();
    idle(1);
    @(negedge clk);
    chk("dl after release out_valid", int'(bus.out_valid), 1);
    chk("dl after release deadlock", int'(deadlock), 1);
    step();
    @(negedge clk);
    chk("dl sticky deadlock", int'(deadlock), 1);

    // Reset asserted mid-stall: w3 r10 still busy.
    step();
    drive(1, 3, 1, 2, 10, 0, 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst load in_ready", int'(bus.in_ready), 1);
    step();
    idle(1);
    @(negedge clk);
    chk("rst stalled out_valid", int'(bus.out_valid), 0);
    chk("rst stalled in_ready", int'(bus.in_ready), 0);
    #1 reset_n = 1'b0;
    #1;
    chk("rst async in_ready", int'(bus.in_ready), 1);
    chk("rst async out_valid", int'(bus.out_valid), 0);
    chk("rst async deadlock", int'(deadlock), 0);
    chk("rst async release_err", int'(release_err), 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rst post out_valid", int'(bus.out_valid), 0);
    chk("rst post in_ready", int'(bus.in_ready), 1);
    // Former busy bits w1 r12/r14 and w3 r10 must all be gone.
    step();
    drive(1, 1, 1, 14, 12, 14, 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst clean load in_ready", int'(bus.in_ready), 1);
    step();
    drive(1, 3, 0, 0, 10, 0, 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst clean w1 out_valid", int'(bus.out_valid), 1);
    chk("rst clean w1 out_rd", int'(bus.out_rd), 14);
    step();
    idle(1);
    @(negedge clk);
    chk("rst clean w3 out_valid", int'(bus.out_valid), 1);
    chk("rst clean w3 out_wid", int'(bus.out_wid), 3);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
